// File: rtl/logicnet_input_packer.sv
// logicnet_input_packer: packs valid/ready feature beats into flat layer-0 vectors; LOGICNET_PACKER_DBUF_EN adds a fill buffer for full throughput
module logicnet_input_packer #(
  parameter int FEAT_BITS = 2,
  parameter int NUM_FEAT  = 16,
  parameter int IDX_W     = $clog2(NUM_FEAT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NUM_FEAT*FEAT_BITS-1:0] m_data,
  output logic                          err
);
  localparam int VW = NUM_FEAT * FEAT_BITS;
  typedef enum logic {FILL, HOLD} state_t;
  state_t          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            drop_q, drop_d;
  logic [VW-1:0]   fill_q, fill_d, m_data_q, m_data_d, packed_v;
  logic            s_ready_q, s_ready_d, m_valid_q, m_valid_d, err_q, err_d;
  logic            beat, last_slot, commit;
  // fill buffer with the current beat merged into slot idx
  always_comb begin
    packed_v = fill_q;
    packed_v[idx_q*FEAT_BITS +: FEAT_BITS] = s_data;
  end
  // next-state: slot fill, malformed-sample drop, and output buffer hand-off
  always_comb begin
    beat      = s_valid && s_ready_q;
    last_slot = idx_q == IDX_W'(NUM_FEAT - 1);
    state_d   = state_q;
    idx_d     = idx_q;
    drop_d    = drop_q;
    fill_d    = fill_q;
    m_data_d  = m_data_q;
    m_valid_d = (m_valid_q && m_ready) ? 1'b0 : m_valid_q;
    err_d     = 1'b0;
    commit    = 1'b0;
    if (state_q == FILL && beat) begin
      if (drop_q) begin
        drop_d = !s_last;
      end else if (s_last && last_slot) begin
        idx_d  = '0;
        commit = 1'b1;
      end else if (s_last || last_slot) begin
        idx_d  = '0;
        err_d  = 1'b1;
        drop_d = !s_last;
      end else begin
        fill_d = packed_v;
        idx_d  = idx_q + 1'b1;
      end
    end
`ifdef LOGICNET_PACKER_DBUF_EN
    if (commit) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = packed_v;
        m_valid_d = 1'b1;
      end else begin
        fill_d  = packed_v;
        state_d = HOLD;
      end
    end
    if (state_q == HOLD && m_ready) begin
      m_data_d  = fill_q;
      m_valid_d = 1'b1;
      state_d   = FILL;
    end
`else
    if (commit) begin
      m_data_d  = packed_v;
      m_valid_d = 1'b1;
      state_d   = HOLD;
    end
    if (state_q == HOLD && m_ready) state_d = FILL;
`endif
    s_ready_d = state_d == FILL;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      drop_q    <= 1'b0;
      fill_q    <= '0;
      m_data_q  <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drop_q    <= drop_d;
      fill_q    <= fill_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;
endmodule

// File: tb/tb_logicnet_input_packer.sv
// tb_logicnet_input_packer: scoreboard bench for the input packer with NUM_FEAT=4, FEAT_BITS=2
module tb_logicnet_input_packer;
  localparam int FB = 2;
  localparam int NF = 4;
  localparam int VW = NF * FB;
  localparam bit DBUF =
`ifdef LOGICNET_PACKER_DBUF_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, s_last = 0, m_valid, m_ready = 0, err;
  logic [FB-1:0] s_data = 0;
  logic [VW-1:0] m_data;
  logic [VW-1:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0, err_cnt = 0, popped = 0, pushed = 0, stalls = 0;
  logicnet_input_packer #(.FEAT_BITS(FB), .NUM_FEAT(NF)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic push(input logic [VW-1:0] v);
    exp_q.push_back(v);
    pushed++;
  endtask
  task automatic beat(input logic [FB-1:0] d, input logic l);
    int n = 0;
    s_valid = 1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 50) chk("beat_accept_timeout", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 0;
    s_last  = 0;
  endtask
  task automatic sample(input logic [FB-1:0] a, b, c, d);
    beat(a, 0); beat(b, 0); beat(c, 0); beat(d, 1);
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_vector: got %0h expected none", m_data);
      end else begin
        chk("vector", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        popped++;
      end
    end
    if (!rst && err) err_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 1);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_err", {31'd0, err}, 0);
    rst = 0;
    m_ready = 1;
    @(negedge clk);
    push(8'h39);
    sample(1, 2, 3, 0);
    chk("lat_m_valid", {31'd0, m_valid}, 1);
    chk("lat_m_data", {24'd0, m_data}, 32'h39);
    chk("hold_s_ready", {31'd0, s_ready}, {31'd0, DBUF});
    @(negedge clk);
    chk("after_xfer_m_valid", {31'd0, m_valid}, 0);
    chk("after_xfer_s_ready", {31'd0, s_ready}, 1);
    m_ready = 0;
    push(8'hC6);
    sample(2, 1, 0, 3);
    for (int i = 0; i < 5; i++) begin
      s_valid = !DBUF;
      s_data  = 3;
      s_last  = 1;
      chk("stall_m_valid", {31'd0, m_valid}, 1);
      chk("stall_m_data", {24'd0, m_data}, 32'hC6);
      chk("stall_s_ready", {31'd0, s_ready}, {31'd0, DBUF});
      @(negedge clk);
    end
    s_valid = 0;
    s_last  = 0;
    m_ready = 1;
    @(negedge clk);
    chk("stall_done_m_valid", {31'd0, m_valid}, 0);
    chk("stall_done_s_ready", {31'd0, s_ready}, 1);
    beat(1, 0);
    beat(2, 1);
    chk("early_last_err", {31'd0, err}, 1);
    chk("early_last_no_vec", {31'd0, m_valid}, 0);
    push(8'hFF);
    sample(3, 3, 3, 3);
    beat(0, 0); beat(1, 0); beat(2, 0); beat(3, 0);
    chk("missing_last_err", {31'd0, err}, 1);
    beat(1, 0);
    chk("drop_no_err", {31'd0, err}, 0);
    beat(2, 1);
    chk("drop_end_no_err", {31'd0, err}, 0);
    push(8'hE4);
    sample(0, 1, 2, 3);
    beat(1, 0);
    beat(1, 0);
    rst = 1;
    #1;
    chk("arst_s_ready", {31'd0, s_ready}, 1);
    chk("arst_m_valid", {31'd0, m_valid}, 0);
    chk("arst_m_data", {24'd0, m_data}, 0);
    chk("arst_err", {31'd0, err}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    push(8'h1B);
    sample(3, 2, 1, 0);
    chk("post_rst_m_data", {24'd0, m_data}, 32'h1B);
    chk("post_rst_err", {31'd0, err}, 0);
`ifdef LOGICNET_PACKER_DBUF_EN
    stalls = 0;
    push(8'h55); sample(1, 1, 1, 1);
    push(8'hCC); sample(0, 3, 0, 3);
    push(8'h33); sample(3, 0, 3, 0);
    chk("dbuf_no_stall", stalls, 0);
    @(negedge clk);
    m_ready = 0;
    push(8'h40); sample(0, 0, 0, 1);
    chk("dbuf_one_held_s_ready", {31'd0, s_ready}, 1);
    push(8'hAA); sample(2, 2, 2, 2);
    chk("dbuf_full_s_ready", {31'd0, s_ready}, 0);
    chk("dbuf_full_m_valid", {31'd0, m_valid}, 1);
    chk("dbuf_full_m_data", {24'd0, m_data}, 32'h40);
    m_ready = 1;
    @(negedge clk);
    chk("dbuf_move_m_valid", {31'd0, m_valid}, 1);
    chk("dbuf_move_m_data", {24'd0, m_data}, 32'hAA);
    chk("dbuf_move_s_ready", {31'd0, s_ready}, 1);
    @(negedge clk);
    chk("dbuf_drain_m_valid", {31'd0, m_valid}, 0);
`endif
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("vectors_seen", popped, pushed);
    chk("err_pulses", err_cnt, 2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
